// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and helpers for the AES key schedule.
//   word_t / rkey_t   : 32-bit schedule word and 128-bit round key
//   state_t           : controller states (IDLE, EXPAND, READY)
//   nk_to_*           : derived sizes from the key length in words
//   sub_word / rcon   : S-box substitution and round constants
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  function automatic int nk_to_nr(input int nk);
    return nk + 6;
  endfunction

  function automatic int nk_to_nwords(input int nk);
    return 4 * (nk_to_nr(nk) + 1);
  endfunction

  // ceil((NWORDS - NK) / NK)
  function automatic int nk_to_steps(input int nk);
    return (nk_to_nwords(nk) - nk + nk - 1) / nk;
  endfunction

  // Forward S-box, entry 0 in the MSBs.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_expansion.sv
// key_expansion: one combinational Nk-word AES key-expansion step.
//   i_prev  : last NK schedule words, oldest word in the MSBs
//   i_round : round number s (selects Rcon)
//   o_next  : the NK words that follow, first new word in the MSBs
module key_expansion
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [32*NK-1:0] i_prev,
  input  logic [3:0]       i_round,
  output logic [32*NK-1:0] o_next
);

  word_t w_nw [NK];
  word_t w_temp;

  always_comb begin
    w_temp = sub_word({i_prev[23:0], i_prev[31:24]}) ^ {rcon(i_round), 24'h0};
    w_nw[0] = i_prev[32*NK-1 -: 32] ^ w_temp;
    for (int j = 1; j < NK; j++) begin
      w_temp = w_nw[j-1];
      // AES-256 applies an extra SubWord halfway through each step.
      if (NK == 8 && j == 4) w_temp = sub_word(w_temp);
      w_nw[j] = i_prev[32*(NK-1-j) +: 32] ^ w_temp;
    end
  end

  for (genvar g = 0; g < NK; g++) begin : g_pack
    assign o_next[32*(NK-1-g) +: 32] = w_nw[g];
  end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// aes_key_schedule_ctrl: builds the full AES round-key schedule one Nk-word
// step per clock and serves 128-bit round keys with a per-round valid flag.
//   clk, rst_n          : clock, async active-low reset
//   zeroize             : (AES_KS_ZEROIZE_EN only) wipe schedule, go IDLE
//   key_in/key_valid    : cipher key handshake, key_ready = can accept
//   busy, done          : expansion in progress / one-cycle completion pulse
//   rk_rd_idx           : round-key index 0..NR
//   rk_rd_data/valid    : registered round key and its availability
// Optional feature macro: AES_KS_ZEROIZE_EN
//
// state  | meaning
// IDLE   | no schedule stored
// EXPAND | one expansion step per clock
// READY  | full schedule held
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef AES_KS_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic [32*NK-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       rk_rd_idx,
  output rkey_t            rk_rd_data,
  output logic             rk_rd_valid
);

  localparam int NR     = nk_to_nr(NK);
  localparam int NWORDS = nk_to_nwords(NK);
  localparam int STEPS  = nk_to_steps(NK);

  state_t            r_state;
  logic [3:0]        r_s;
  logic [3:0]        r_avail;
  logic              r_fin;
  word_t             r_buf     [NWORDS];
  word_t             w_buf_nxt [NWORDS];
  logic              w_zero;
  logic              w_accept;
  logic [3:0]        w_avail_nxt;
  int                w_words;
  logic [32*NK-1:0]  w_prev;
  logic [32*NK-1:0]  w_step;
  rkey_t             w_rd_data;
  logic              w_rd_valid;

`ifdef AES_KS_ZEROIZE_EN
  assign w_zero = zeroize;
`else
  assign w_zero = 1'b0;
`endif

  assign w_accept = key_valid & key_ready;

  // Window of the last NK words written, i.e. step s-1's output.
  always_comb begin
    w_prev = '0;
    for (int j = 0; j < NK; j++) begin
      if (r_s != 4'd0 && (int'(r_s) - 1) * NK + j < NWORDS)
        w_prev[32*(NK-1-j) +: 32] = r_buf[(int'(r_s) - 1) * NK + j];
    end
  end

  key_expansion #(.NK(NK)) u_step (
    .i_prev  (w_prev),
    .i_round (r_s),
    .o_next  (w_step)
  );

  always_comb begin
    w_buf_nxt = r_buf;
    if (w_zero) begin
      for (int i = 0; i < NWORDS; i++) w_buf_nxt[i] = '0;
    end else if (w_accept) begin
      for (int j = 0; j < NK; j++) w_buf_nxt[j] = key_in[32*(NK-1-j) +: 32];
    end else if (r_state == EXPAND) begin
      // The final step of AES-192/256 overruns the schedule; drop the excess.
      for (int j = 0; j < NK; j++)
        if (int'(r_s) * NK + j < NWORDS) w_buf_nxt[int'(r_s) * NK + j] = w_step[32*(NK-1-j) +: 32];
    end
  end

  always_comb begin
    w_avail_nxt = r_avail;
    w_words     = 0;
    if (w_zero) begin
      w_avail_nxt = '0;
    end else if (w_accept) begin
      w_avail_nxt = 4'(NK / 4);
    end else if (r_state == EXPAND) begin
      w_words = (int'(r_s) + 1) * NK;
      if (w_words / 4 > NR + 1) w_avail_nxt = 4'(NR + 1);
      else                      w_avail_nxt = 4'(w_words / 4);
    end
  end

  // Reads see this edge's writes by indexing the next-state buffer.
  always_comb begin
    w_rd_data  = '0;
    w_rd_valid = 1'b0;
    if (int'(rk_rd_idx) <= NR) begin
      w_rd_data  = {w_buf_nxt[4*int'(rk_rd_idx)],     w_buf_nxt[4*int'(rk_rd_idx) + 1],
                    w_buf_nxt[4*int'(rk_rd_idx) + 2], w_buf_nxt[4*int'(rk_rd_idx) + 3]};
      w_rd_valid = rk_rd_idx < w_avail_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_avail     <= '0;
      r_fin       <= 1'b0;
      key_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      rk_rd_data  <= '0;
      rk_rd_valid <= 1'b0;
      for (int i = 0; i < NWORDS; i++) r_buf[i] <= '0;
    end else begin
      r_buf       <= w_buf_nxt;
      r_avail     <= w_avail_nxt;
      rk_rd_data  <= w_rd_data;
      rk_rd_valid <= w_rd_valid;
      done        <= 1'b0;
      if (w_zero) begin
        r_state   <= IDLE;
        r_fin     <= 1'b0;
        key_ready <= 1'b1;
        busy      <= 1'b0;
      end else if (w_accept) begin
        r_state   <= EXPAND;
        r_s       <= 4'd1;
        r_fin     <= 1'b0;
        key_ready <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (r_state)
          EXPAND: begin
            r_s <= r_s + 4'd1;
            if (r_s == 4'(STEPS)) begin
              r_state   <= READY;
              r_fin     <= 1'b1;
              key_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
          default: begin
            // done trails the READY transition by one edge; a restart or
            // zeroize on that edge suppresses it.
            done  <= r_fin;
            r_fin <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb_aes_key_schedule_ctrl: directed checks of the key schedule controller
// for AES-128/192/256 using FIPS-197 vectors.
module tb_aes_key_schedule_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic zeroize = 1'b0;
  logic [127:0] kin4;
  logic [191:0] kin6;
  logic [255:0] kin8;
  logic kv4, kv6, kv8, kr4, kr6, kr8, busy4, busy6, busy8, done4, done6, done8;
  logic [3:0] idx4, idx6, idx8;
  logic [127:0] d4, d6, d8;
  logic v4, v6, v8;
  int errors = 0;
  int checks = 0;

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KOTH = 256'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  aes_key_schedule_ctrl #(.NK(4)) u4 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_in(kin4), .key_valid(kv4), .key_ready(kr4), .busy(busy4), .done(done4),
    .rk_rd_idx(idx4), .rk_rd_data(d4), .rk_rd_valid(v4));

  aes_key_schedule_ctrl #(.NK(6)) u6 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize(1'b0),
`endif
    .key_in(kin6), .key_valid(kv6), .key_ready(kr6), .busy(busy6), .done(done6),
    .rk_rd_idx(idx6), .rk_rd_data(d6), .rk_rd_valid(v6));

  aes_key_schedule_ctrl #(.NK(8)) u8 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize(1'b0),
`endif
    .key_in(kin8), .key_valid(kv8), .key_ready(kr8), .busy(busy8), .done(done8),
    .rk_rd_idx(idx8), .rk_rd_data(d8), .rk_rd_valid(v8));

  task automatic drive_key(input int nk, input logic [255:0] key, input logic v);
    case (nk)
      4:       begin kin4 = key[127:0]; kv4 = v; end
      6:       begin kin6 = key[191:0]; kv6 = v; end
      default: begin kin8 = key;        kv8 = v; end
    endcase
  endtask

  // Returns #1 after the accept edge.
  task automatic do_accept(input int nk, input logic [255:0] key);
    drive_key(nk, key, 1'b1);
    @(posedge clk); #1;
    drive_key(nk, key, 1'b0);
  endtask

  function automatic logic done_of(input int nk);
    case (nk)
      4:       return done4;
      6:       return done6;
      default: return done8;
    endcase
  endfunction

  // Number of edges until done is seen, -1 on timeout.
  task automatic wait_done(input int nk, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done_of(nk)) begin lat = k; break; end
    end
  endtask

  task automatic read_rk(input int nk, input logic [3:0] idx, output logic [127:0] d, output logic v);
    case (nk)
      4:       idx4 = idx;
      6:       idx6 = idx;
      default: idx8 = idx;
    endcase
    @(posedge clk); #1;
    case (nk)
      4:       begin d = d4; v = v4; end
      6:       begin d = d6; v = v6; end
      default: begin d = d8; v = v8; end
    endcase
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    checks++; if (kr4 !== 1'b1) begin errors++; $display("FAIL rst_key_ready: got %b expected 1", kr4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done4); end
    checks++; if (d4 !== 128'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", d4); end
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", v4); end
    checks++; if (kr6 !== 1'b1 || kr8 !== 1'b1) begin errors++; $display("FAIL rst_key_ready_6_8: got %b%b expected 11", kr6, kr8); end
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nk4();
    int lat;
    logic [127:0] d;
    logic v;
    do_accept(4, K128);
    checks++; if (kr4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL nk4_accept_flags: got ready=%b busy=%b expected 0 1", kr4, busy4); end
    wait_done(4, lat);
    checks++; if (lat != 11) begin errors++; $display("FAIL nk4_latency: got %0d expected 11", lat); end
    @(posedge clk); #1;
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL nk4_done_width: got %b expected 0", done4); end
    checks++; if (kr4 !== 1'b1 || busy4 !== 1'b0) begin errors++; $display("FAIL nk4_ready_flags: got ready=%b busy=%b expected 1 0", kr4, busy4); end
    read_rk(4, 4'd1, d, v);
    checks++; if (d !== 128'ha0fafe1788542cb123a339392a6c7605 || v !== 1'b1) begin errors++; $display("FAIL nk4_rk1: got %h v=%b expected a0fafe1788542cb123a339392a6c7605 v=1", d, v); end
    read_rk(4, 4'd10, d, v);
    checks++; if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || v !== 1'b1) begin errors++; $display("FAIL nk4_rk10: got %h v=%b expected d014f9a8c9ee2589e13f0cc8b6630ca6 v=1", d, v); end
    read_rk(4, 4'd0, d, v);
    checks++; if (d !== K128[127:0] || v !== 1'b1) begin errors++; $display("FAIL nk4_rk0: got %h v=%b expected %h v=1", d, v, K128[127:0]); end
  endtask

  task automatic test_nk6();
    int lat;
    logic [127:0] d;
    logic v;
    do_accept(6, K192);
    wait_done(6, lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL nk6_latency: got %0d expected 9", lat); end
    read_rk(6, 4'd12, d, v);
    checks++; if (d !== 128'he98ba06f448c773c8ecc720401002202 || v !== 1'b1) begin errors++; $display("FAIL nk6_rk12: got %h v=%b expected e98ba06f448c773c8ecc720401002202 v=1", d, v); end
    read_rk(6, 4'd1, d, v);
    checks++; if (d !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5 || v !== 1'b1) begin errors++; $display("FAIL nk6_rk1: got %h v=%b expected 62f8ead2522c6b7bfe0c91f72402f5a5 v=1", d, v); end
    read_rk(6, 4'd13, d, v);
    checks++; if (d !== 128'h0 || v !== 1'b0) begin errors++; $display("FAIL nk6_idx_over: got %h v=%b expected 0 v=0", d, v); end
  endtask

  task automatic test_nk8();
    int lat;
    logic [127:0] d;
    logic v;
    do_accept(8, K256);
    wait_done(8, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL nk8_latency: got %0d expected 8", lat); end
    read_rk(8, 4'd14, d, v);
    checks++; if (d !== 128'hfe4890d1e6188d0b046df344706c631e || v !== 1'b1) begin errors++; $display("FAIL nk8_rk14: got %h v=%b expected fe4890d1e6188d0b046df344706c631e v=1", d, v); end
    read_rk(8, 4'd1, d, v);
    checks++; if (d !== 128'h1f352c073b6108d72d9810a30914dff4 || v !== 1'b1) begin errors++; $display("FAIL nk8_rk1: got %h v=%b expected 1f352c073b6108d72d9810a30914dff4 v=1", d, v); end
    read_rk(8, 4'd15, d, v);
    checks++; if (d !== 128'h0 || v !== 1'b0) begin errors++; $display("FAIL nk8_idx_over: got %h v=%b expected 0 v=0", d, v); end
  endtask

  task automatic test_poll();
    int first;
    logic [127:0] got;
    logic [127:0] d;
    logic v;
    first = -1;
    got = '0;
    idx4 = 4'd3;
    do_accept(4, K128);
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL poll_accept_valid: got %b expected 0", v4); end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (v4 === 1'b1 && first < 0) begin first = k; got = d4; end
    end
    checks++; if (first != 3) begin errors++; $display("FAIL poll_first_valid: got cycle %0d expected 3", first); end
    checks++; if (got !== 128'h3d80477d4716fe3e1e237e446d7a883b) begin errors++; $display("FAIL poll_rk3: got %h expected 3d80477d4716fe3e1e237e446d7a883b", got); end
    read_rk(4, 4'd11, d, v);
    checks++; if (d !== 128'h0 || v !== 1'b0) begin errors++; $display("FAIL poll_idx11: got %h v=%b expected 0 v=0", d, v); end
  endtask

  task automatic test_busy_ignore_and_reset();
    int lat;
    logic [127:0] d;
    logic v;
    do_accept(4, K128);
    drive_key(4, KOTH, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      checks++; if (kr4 !== 1'b0) begin errors++; $display("FAIL hold_key_ready c%0d: got %b expected 0", k, kr4); end
    end
    drive_key(4, KOTH, 1'b0);
    wait_done(4, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL hold_done: got %0d expected 3", lat); end
    read_rk(4, 4'd10, d, v);
    checks++; if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || v !== 1'b1) begin errors++; $display("FAIL hold_rk10: got %h v=%b expected d014f9a8c9ee2589e13f0cc8b6630ca6 v=1", d, v); end
    read_rk(4, 4'd0, d, v);
    checks++; if (d !== K128[127:0]) begin errors++; $display("FAIL hold_rk0: got %h expected %h", d, K128[127:0]); end
    do_accept(4, K128);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (kr4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL midrst_flags: got ready=%b busy=%b done=%b expected 1 0 0", kr4, busy4, done4); end
    checks++; if (d4 !== 128'h0 || v4 !== 1'b0) begin errors++; $display("FAIL midrst_read: got %h v=%b expected 0 v=0", d4, v4); end
    #2 rst_n = 1'b1;
    read_rk(4, 4'd0, d, v);
    checks++; if (d !== 128'h0 || v !== 1'b0) begin errors++; $display("FAIL postrst_read: got %h v=%b expected 0 v=0", d, v); end
    checks++; if (busy4 !== 1'b0 || kr4 !== 1'b1) begin errors++; $display("FAIL postrst_flags: got busy=%b ready=%b expected 0 1", busy4, kr4); end
  endtask

`ifdef AES_KS_ZEROIZE_EN
  task automatic test_zeroize();
    logic [127:0] d;
    logic v;
    idx4 = 4'd0;
    do_accept(4, K128);
    repeat (10) @(posedge clk);
    #1 zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL zero_done: got %b expected 0", done4); end
    checks++; if (d4 !== 128'h0 || v4 !== 1'b0) begin errors++; $display("FAIL zero_read: got %h v=%b expected 0 v=0", d4, v4); end
    checks++; if (kr4 !== 1'b1 || busy4 !== 1'b0) begin errors++; $display("FAIL zero_flags: got ready=%b busy=%b expected 1 0", kr4, busy4); end
    read_rk(4, 4'd1, d, v);
    checks++; if (d !== 128'h0 || v !== 1'b0) begin errors++; $display("FAIL zero_rk1: got %h v=%b expected 0 v=0", d, v); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL zero_done_late: got %b expected 0", done4); end
  endtask
`endif

  initial begin
    kin4 = '0; kin6 = '0; kin8 = '0;
    kv4 = 1'b0; kv6 = 1'b0; kv8 = 1'b0;
    idx4 = '0; idx6 = '0; idx8 = '0;
    test_reset();
    test_nk4();
    test_nk6();
    test_nk8();
    test_poll();
    test_busy_ignore_and_reset();
`ifdef AES_KS_ZEROIZE_EN
    test_zeroize();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
Sequences the combinational one-step key expansion function to build the full AES round-key schedule for AES-128, AES-192 or AES-256. The block accepts a cipher key over a valid/ready handshake, iterates one Nk-word expansion step per clock, and stores every word in a local flop buffer. The cipher datapath reads 128-bit round keys by index and may start before expansion completes, because each key read returns a per-round valid flag.

Parameters:
NK, 4, key length in 32-bit words; legal values are 4, 6 and 8.
NR, NK+6, number of rounds; derived, do not override.
NWORDS, 4*(NR+1), number of schedule words stored (44, 52 or 60).
STEPS, ceil((NWORDS-NK)/NK), number of expansion iterations (10, 8 or 7).

Ports:
clk  in  1  clock; rising edge.
rst_n  in  1  reset; asynchronous, active-low.
key_in  in  32*NK  cipher key, big-endian, word 0 in the MSBs.
key_valid  in  1  key_in is valid this cycle.
key_ready  out  1  block can accept a new key.
busy  out  1  expansion in progress.
done  out  1  one-cycle pulse when the schedule is complete.
rk_rd_idx  in  4  requested round-key index, 0..NR.
rk_rd_data  out  128  words 4*idx .. 4*idx+3 of the schedule; registered.
rk_rd_valid  out  1  rk_rd_data holds a fully written round key.

Behaviour:
- Reset: the state goes to IDLE. key_ready=1, busy=0, done=0, rk_rd_data=0, rk_rd_valid=0. The word buffer and the round-key availability count (rk_avail) are cleared to 0.
- States:
  - IDLE (no schedule stored).
  - EXPAND.
  - READY (a schedule is held).
- key_ready=1 in IDLE and READY and 0 in EXPAND. A key_valid asserted while busy is ignored; there is no queueing.
- Key accept:
  - Acceptance happens on a clock edge where key_valid and key_ready are both 1.
  - At that edge, words 0..NK-1 are written from key_in, the step counter s is set to 1, and the state goes to EXPAND.
  - Also at that edge, rk_avail is set to floor(NK/4). Any previously stored schedule is invalidated by this.
- EXPAND:
  - Each edge presents the last NK stored words and round number s to the expansion step.
  - The step output words are written at s*NK .. s*NK+NK-1. Words at index NWORDS or above are discarded (last step for NK=6 and NK=8).
  - rk_avail is updated to min(floor(words_written/4), NR+1). Then s is incremented.
- Finish: after the edge that writes step STEPS, the state goes to READY. done is 1 for exactly the following cycle.
- Latency from the accept edge to done=1 is STEPS+1 cycles: 11 for NK=4, 9 for NK=6, 8 for NK=8.
- A new key accepted in READY restarts expansion. done does not pulse for the old key.
- Read port (1-cycle latency):
  - At each edge, rk_rd_data is loaded with the indexed words.
  - rk_rd_valid is loaded with (rk_rd_idx < rk_avail), evaluated after that edge's writes.
  - When idx > NR: rk_rd_data=0 and rk_rd_valid=0.
- Reads concurrent with writes to the same words return the newly written value; the write is visible in the same edge's registered read.
- Asserting rst_n low mid-expansion aborts the expansion immediately. All state returns to reset values.

Optional Feature:
AES_KS_ZEROIZE_EN
- With the macro defined: adds input port zeroize (1 bit).
  - When zeroize=1 at an edge, the whole buffer, rk_avail, rk_rd_data and rk_rd_valid are cleared, and the state goes to IDLE.
  - zeroize has priority over key accept and over the expansion step. done is not pulsed.
- Without the macro: the port is absent. A schedule is held until the next key or reset.

Decomposition:
- Shared package aes_pkg holds:
  - the NK-to-NR and NWORDS/STEPS constant functions;
  - the round-constant table;
  - the state enum (IDLE, EXPAND, READY);
  - the word typedef (32 bits) and the round-key typedef (128 bits).
- One sub-module: key_expansion, a combinational single Nk-word step.
  - Instantiated once, parameterised by NK.
  - Fed by the buffer's last NK words and by s.
- Buffer, counters and the FSM live in aes_key_schedule_ctrl.

Test Plan:
1. NK=4, key 2b7e151628aed2a6abf7158809cf4f3c -> round key 1 = a0fafe1788542cb123a339392a6c7605. Round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. done pulses 11 cycles after accept.
2. NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> round key 12 = e98ba06f448c773c8ecc720401002202. done pulses 9 cycles after accept.
3. NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> round key 14 = fe4890d1e6188d0b046df344706c631e. done pulses 8 cycles after accept.
4. NK=4: poll rk_rd_idx=3 every cycle from accept -> rk_rd_valid first reads 1 in the cycle after step 3 is written, with the correct data. Setting idx=11 -> rk_rd_valid=0 and data=0.
5. key_valid held during EXPAND with a different key -> key_ready stays 0 and the original schedule completes unchanged. Then rst_n low at step 5 -> all outputs read 0 and key_ready=1 while reset is asserted. After reset is released, reads return valid=0.
6. (AES_KS_ZEROIZE_EN) zeroize pulse in READY -> the next read of idx 0 gives data=0 and valid=0, state is IDLE, and there is no done pulse.
